uart_rx_packet: RTL and testbench
=================================

// Module: uart_rx_packet
// PURPOSE
//  Byte receiver feeding the packet-level UART framer. Samples async RxD, deserialises 8N1 bytes,
//  flags line idle and pulses end-of-packet after an inter-byte gap so the framer can check MSGID/CSUM.
//  Sits directly upstream of the framer's RxD_data/RxD_data_ready/RxD_idle/RxD_endofpacket inputs.
// PARAMETERS
//  ClkFrequency  12000000  system clock in Hz
//  Baud          2000000   line rate in bit/s; CPB = ClkFrequency/Baud (integer division, must be >= 4)
//  IdleBits      16        line-high bit times after a stop bit before idle/end-of-packet
// PORTS
//  clk              in   1  system clock; all logic on posedge
//  rst              in   1  synchronous, active-high reset
//  RxD              in   1  asynchronous serial input, idle high
//  RxD_data         out  8  last good byte, LSB received first; held until next good byte
//  RxD_data_ready   out  1  1-clk pulse: RxD_data valid this cycle
//  RxD_idle         out  1  level: line high >= IdleBits*CPB clocks since last stop bit
//  RxD_endofpacket  out  1  1-clk pulse when RxD_idle rises and >=1 byte arrived since last pulse
//  RxD_frame_err    out  1  1-clk pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; sync FFs = 1; idle counter = 0; byte-seen flag = 0.
//  - RxD through 2-FF synchroniser (rxs); all decisions use rxs. 2 clk input latency.
//  - Bit timer: counts 0..CPB-1, reloadable; "mid" = count reaches CPB/2-1 (start), CPB-1 (others).
//  - FSM: IDLE -> START on rxs==0. START: at CPB/2 clocks recheck rxs; 0 -> DATA (bit=0), 1 -> IDLE (glitch).
//    DATA: every CPB clocks sample rxs into shift reg LSB-first; after bit 7 -> STOP.
//    STOP: after CPB clocks sample rxs; 1 -> load RxD_data, pulse RxD_data_ready next clk, set byte-seen;
//    0 -> pulse RxD_frame_err, no data_ready, byte-seen unchanged. Either way -> IDLE.
//  - Back-to-back: falling edge accepted in the cycle after leaving STOP; no extra gap required.
//  - Idle counter: cleared on leaving IDLE; in IDLE counts up while rxs==1, saturates at IdleBits*CPB;
//    rxs==0 starts a frame. RxD_idle = (counter == IdleBits*CPB) && state==IDLE.
//  - RxD_endofpacket: the cycle the counter reaches saturation and byte-seen==1; clears byte-seen.
//    Never pulses without a preceding good byte; never same cycle as RxD_data_ready.
//  - Line held low (break): frame-error each 10 bit times; no idle, no EOP.
//  - rst mid-frame: partial byte dropped, no pulses, resumes hunting for start after release.
//  - Counter widths: $clog2(IdleBits*CPB+1) and $clog2(CPB); no wrap permitted.
// CONFIGURATION
//  UART_RX_FILTER_EN defined: 3-tap majority filter after synchroniser (rxs = maj of last 3 samples),
//   adds 2 clk latency, rejects single-clock glitches; CPB must be >= 6.
//  Undefined: rxs is the raw synchroniser output; no glitch rejection beyond START recheck.
// STRUCTURE
//  Package uart_pkg: FSM state typedef (IDLE, START, DATA, STOP), CPB/idle-limit localparam functions,
//   shared with uart_tx-side blocks.
//  Sub-module uart_bit_timer: CPB-cycle counter with restart input and half/full-bit tick outputs.
// TESTING (12 MHz, 2 Mbaud, CPB=6, IdleBits=16)
//  1 byte 0xA5, then line high -> RxD_data=0xA5 with one data_ready pulse; EOP pulse 96 clk after stop sample.
//  10 bytes 0x77,0x72,0x69,0x74,... back-to-back -> 10 data_ready pulses in order, exactly 1 EOP at end.
//  0x3C with stop bit forced 0 -> 1 frame_err pulse, no data_ready, no EOP after idle.
//  2-clk low glitch on idle line -> no data_ready, no frame_err; RxD_idle stays 1 (with _EN: no FSM exit).
//  rst asserted during bit 4 of 0xFF, released, then 0x11 sent -> only 0x11 delivered, then 1 EOP.
//  Gap of 15 bit times between bytes -> no EOP mid-packet; gap of 16 -> EOP, then second byte starts new packet.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and the helpers that derive
// clocks-per-bit and the idle timeout from the clock and baud parameters.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Integer division is intentional: any fractional part is absorbed by mid-bit sampling.
    function automatic int calc_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int calc_idle_limit(input int clk_hz, input int baud, input int idle_bits);
        return idle_bits * (clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running clocks-per-bit counter with a restart input; raises a tick at the
// half-bit point and at the full-bit point of the current bit period.
module uart_bit_timer #(
    parameter int CPB = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_half_tick,
    output logic o_full_tick
);
    localparam int TW = $clog2(CPB);
    localparam logic [TW-1:0] HALF_LAST = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CPB - 1);

    logic [TW-1:0] r_count;

    // Wraps explicitly at CPB-1 so a non-power-of-two CPB never overruns the bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_restart || (r_count == FULL_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_half_tick = (r_count == HALF_LAST);
    assign o_full_tick = (r_count == FULL_LAST);

endmodule

// File: rtl/uart_rx_packet.sv
// 8N1 byte receiver with line-idle detection and end-of-packet pulse for the packet framer.
// Optional UART_RX_FILTER_EN adds a 3-tap majority glitch filter behind the synchroniser.
module uart_rx_packet #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 2000000,
    parameter int IdleBits     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_idle,
    output logic       RxD_endofpacket,
    output logic       RxD_frame_err
);
    import uart_pkg::*;

    localparam int CPB        = calc_cpb(ClkFrequency, Baud);
    localparam int IDLE_LIMIT = calc_idle_limit(ClkFrequency, Baud, IdleBits);
    localparam int IW         = $clog2(IDLE_LIMIT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);

    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_FILTER_EN
    logic [2:0] r_flt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flt <= 3'b111;
        end else begin
            r_flt <= {r_flt[1:0], r_sync2};
        end
    end

    assign w_rxs = (r_flt[0] & r_flt[1]) | (r_flt[0] & r_flt[2]) | (r_flt[1] & r_flt[2]);
`else
    assign w_rxs = r_sync2;
`endif

    uart_state_t r_state;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        r_ferr;
    logic        r_eop;
    logic        r_byte_seen;
    logic [IW-1:0] r_idle_cnt;

    logic w_restart;
    logic w_half_tick;
    logic w_full_tick;

    // Realign the bit timer on a falling edge seen in IDLE and again once the start bit is confirmed.
    assign w_restart = ((r_state == IDLE) && !w_rxs) || ((r_state == START) && w_half_tick);

    uart_bit_timer #(
        .CPB(CPB)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_restart   (w_restart),
        .o_half_tick (w_half_tick),
        .o_full_tick (w_full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_ferr      <= 1'b0;
            r_eop       <= 1'b0;
            r_byte_seen <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_eop   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                    end else if (r_idle_cnt != IDLE_MAX) begin
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                        if ((r_idle_cnt == IDLE_MAX - IW'(1)) && r_byte_seen) begin
                            r_eop       <= 1'b1;
                            r_byte_seen <= 1'b0;
                        end
                    end
                end
                // The idle count is held here so a rejected glitch does not restart the timeout.
                START: begin
                    if (w_half_tick) begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                        end else begin
                            r_state    <= DATA;
                            r_bit_idx  <= '0;
                            r_idle_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_full_tick) begin
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_full_tick) begin
                        r_state <= IDLE;
                        if (w_rxs) begin
                            r_data      <= r_shift;
                            r_ready     <= 1'b1;
                            r_byte_seen <= 1'b1;
                            // The high stop-bit sample is the first line-high clock of the gap.
                            r_idle_cnt  <= IW'(1);
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign RxD_data        = r_data;
    assign RxD_data_ready  = r_ready;
    assign RxD_idle        = (r_idle_cnt == IDLE_MAX) && (r_state == IDLE);
    assign RxD_endofpacket = r_eop;
    assign RxD_frame_err   = r_ferr;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet at 12 MHz / 2 Mbaud (6 clocks per bit, 16 idle bits).
module tb_uart_rx_packet;

    localparam int CPB = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_idle;
    logic       RxD_endofpacket;
    logic       RxD_frame_err;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int rdy_cnt  = 0;
    int eop_cnt  = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int rdy_cyc  = 0;
    int eop_cyc  = 0;
    logic [7:0] rx_log [0:63];

    uart_rx_packet #(
        .ClkFrequency (12000000),
        .Baud         (2000000),
        .IdleBits     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .RxD             (RxD),
        .RxD_data        (RxD_data),
        .RxD_data_ready  (RxD_data_ready),
        .RxD_idle        (RxD_idle),
        .RxD_endofpacket (RxD_endofpacket),
        .RxD_frame_err   (RxD_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            if (rdy_cnt < 64) rx_log[rdy_cnt] = RxD_data;
            rdy_cnt = rdy_cnt + 1;
            rdy_cyc = cyc;
            $display("tb: rx byte 0x%02h at cycle %0d", RxD_data, cyc);
        end
        if (RxD_endofpacket) begin
            eop_cnt = eop_cnt + 1;
            eop_cyc = cyc;
            $display("tb: end-of-packet at cycle %0d", cyc);
        end
        if (RxD_frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            $display("tb: frame error at cycle %0d", cyc);
        end
        if (RxD_data_ready && RxD_endofpacket) both_cnt = both_cnt + 1;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            clks(CPB);
        end
        RxD = stop_bit;
        clks(CPB);
        RxD = 1'b1;
    endtask

    logic [7:0] msg [0:9];
    int base_rdy;
    int base_eop;
    int base_ferr;

    initial begin
        msg = '{8'h77, 8'h72, 8'h69, 8'h74, 8'h65, 8'h20, 8'h64, 8'h61, 8'h74, 8'h61};

        // Reset state
        clks(4);
        check("reset_data",  {24'd0, RxD_data}, 32'h00);
        check("reset_ready", {31'd0, RxD_data_ready}, 32'd0);
        check("reset_idle",  {31'd0, RxD_idle}, 32'd0);
        check("reset_eop",   {31'd0, RxD_endofpacket}, 32'd0);
        check("reset_ferr",  {31'd0, RxD_frame_err}, 32'd0);
        rst = 1'b0;

        // Idle line after reset: idle rises, but no EOP without a byte
        clks(110);
        check("boot_idle", {31'd0, RxD_idle}, 32'd1);
        check("boot_no_eop", eop_cnt, 0);

        // Single byte 0xA5; EOP 96 clocks after stop sample = 95 after data_ready
        send_byte(8'hA5, 1'b1);
        clks(120);
        check("a5_count", rdy_cnt, 1);
        check("a5_data", {24'd0, rx_log[0]}, 32'hA5);
        check("a5_eop_count", eop_cnt, 1);
        check("a5_eop_delay", eop_cyc - rdy_cyc, 95);
        check("a5_data_held", {24'd0, RxD_data}, 32'hA5);

        // Ten back-to-back bytes, one EOP at the end
        base_rdy = rdy_cnt;
        base_eop = eop_cnt;
        for (int i = 0; i < 10; i++) send_byte(msg[i], 1'b1);
        check("burst_idle_low", {31'd0, RxD_idle}, 32'd0);
        check("burst_no_eop_yet", eop_cnt - base_eop, 0);
        clks(120);
        check("burst_count", rdy_cnt - base_rdy, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("burst_byte%0d", i), {24'd0, rx_log[base_rdy + i]}, {24'd0, msg[i]});
        end
        check("burst_eop", eop_cnt - base_eop, 1);

        // 0x3C with low stop bit: one frame error, no data, no EOP
        base_rdy  = rdy_cnt;
        base_eop  = eop_cnt;
        base_ferr = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        clks(120);
        check("ferr_count", ferr_cnt - base_ferr, 1);
        check("ferr_no_ready", rdy_cnt - base_rdy, 0);
        check("ferr_no_eop", eop_cnt - base_eop, 0);
        check("ferr_data_kept", {24'd0, RxD_data}, 32'h61);

        // 2-clock low glitch on idle line
        base_rdy  = rdy_cnt;
        base_ferr = ferr_cnt;
        RxD = 1'b0;
        clks(2);
        RxD = 1'b1;
        clks(12);
        check("glitch_idle", {31'd0, RxD_idle}, 32'd1);
        clks(60);
        check("glitch_no_ready", rdy_cnt - base_rdy, 0);
        check("glitch_no_ferr", ferr_cnt - base_ferr, 0);

        // Reset during bit 4 of 0xFF, then 0x11
        base_rdy  = rdy_cnt;
        base_eop  = eop_cnt;
        base_ferr = ferr_cnt;
        RxD = 1'b0;
        clks(CPB);
        RxD = 1'b1;
        clks(4 * CPB + 3);
        rst = 1'b1;
        clks(2);
        check("midrst_data_cleared", {24'd0, RxD_data}, 32'h00);
        rst = 1'b0;
        clks(30);
        check("midrst_no_ready", rdy_cnt - base_rdy, 0);
        check("midrst_no_ferr", ferr_cnt - base_ferr, 0);
        send_byte(8'h11, 1'b1);
        clks(120);
        check("midrst_count", rdy_cnt - base_rdy, 1);
        check("midrst_data", {24'd0, RxD_data}, 32'h11);
        check("midrst_eop", eop_cnt - base_eop, 1);

        // Gap of 15 bit times keeps the packet open; 16 bit times closes it
        base_rdy = rdy_cnt;
        base_eop = eop_cnt;
        send_byte(8'h41, 1'b1);
        clks(15 * CPB);
        send_byte(8'h42, 1'b1);
        check("gap15_no_eop", eop_cnt - base_eop, 0);
        clks(16 * CPB);
        check("gap16_eop", eop_cnt - base_eop, 1);
        send_byte(8'h43, 1'b1);
        clks(120);
        check("gap_count", rdy_cnt - base_rdy, 3);
        check("gap_byte2", {24'd0, rx_log[base_rdy + 2]}, 32'h43);
        check("gap_second_packet_eop", eop_cnt - base_eop, 2);

        check("never_ready_with_eop", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
